// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter and occupancy tracker in front of a flagless FIFO.
// FIFO read data doubles as the output register of a zero-bubble valid/ready stream.
module fifo_rr_ctrl #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              in_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   in_data,
    output logic [N_REQ-1:0]              in_ready,
    output logic                          fifo_wr_en,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_wdata,
    output logic                          fifo_rd_en,
    input  logic [ID_W+DATA_WIDTH-1:0]    fifo_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_src,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       idx;
    logic                  found;
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Priority starts just after the last winner and wraps around.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // No full-bypass: keeps out_ready off the in_ready path.
    assign fifo_wr_en = !rst && found && !full;
    assign fifo_wdata = {winner, data_arr[winner]};
    assign fifo_rd_en = !rst && !empty && (!out_valid_q || out_ready);

    always_comb begin
        in_ready = '0;
        if (fifo_wr_en) begin
            in_ready[winner] = 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign out_src   = fifo_rdata[ID_W+DATA_WIDTH-1 -: ID_W];

    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (fifo_wr_en && !fifo_rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!fifo_wr_en && fifo_rd_en) begin
            count_d = count_q - 1'b1;
        end
        if (fifo_rd_en) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (fifo_wr_en) begin
            ptr_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= ID_W'(N_REQ - 1);
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Randomized bench for fifo_rr_ctrl: behavioural FIFO stand-in plus a queue-based
// reference model of arbitration, occupancy and output ordering.
module tb_fifo_rr_ctrl;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int IDW   = 2;
    localparam int W     = IDW + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_wdata;
    logic            fifo_rd_en;
    logic [W-1:0]    fifo_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IDW-1:0]  out_src;
    logic [4:0]      count;
    logic            full;
    logic            empty;

    always #5 clk = ~clk;

    fifo_rr_ctrl #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Stand-in for the attached fifo: registered data_out, no flags, rst_n = ~rst.
    logic [W-1:0] fmem [DEPTH];
    int           fwp, frp;
    logic         rst_n;
    assign rst_n = ~rst;

    always @(posedge clk) begin
        if (!rst_n) begin
            fwp <= 0;
            frp <= 0;
        end else begin
            if (fifo_wr_en) begin
                fmem[fwp] <= fifo_wdata;
                fwp       <= (fwp + 1) % DEPTH;
            end
            if (fifo_rd_en) begin
                fifo_rdata <= fmem[frp];
                frp        <= (frp + 1) % DEPTH;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int           m_count;
    bit           m_ov;
    int           m_ptr;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_head;

    // Observation helpers for directed checks
    int           cyc;
    int           dut_grant;
    int           first_grant;
    int           first_ov;
    int           n_acc;
    logic [W-1:0] obs_q[$];

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_ov    = 1'b0;
        m_ptr   = N - 1;
        m_q.delete();
    endtask

    // One clock: inputs are already applied; check at negedge, advance model at posedge.
    task automatic step();
        int           win;
        bit           e_wr, e_rd, e_full;
        logic [N-1:0] e_ir;
        logic [W-1:0] e_wdata;
        @(negedge clk);
        e_full  = (m_count == DEPTH);
        win     = pick(m_ptr, in_valid);
        e_wr    = !rst && (win >= 0) && !e_full;
        e_ir    = '0;
        e_wdata = '0;
        if (e_wr) begin
            e_ir[win] = 1'b1;
            e_wdata   = {2'(win), in_data[win*DW +: DW]};
        end
        e_rd = !rst && (m_count != 0) && (!m_ov || out_ready);

        check_eq("in_ready", 64'(in_ready), 64'(e_ir));
        check_eq("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
        check_eq("fifo_rd_en", 64'(fifo_rd_en), 64'(e_rd));
        check_eq("count", 64'(count), 64'(m_count));
        check_eq("full", 64'(full), 64'(e_full));
        check_eq("empty", 64'(empty), 64'(m_count == 0));
        check_eq("out_valid", 64'(out_valid), 64'(m_ov));
        if (e_wr) check_eq("fifo_wdata", 64'(fifo_wdata), 64'(e_wdata));
        if (m_ov) begin
            check_eq("out_data", 64'(out_data), 64'(m_head[DW-1:0]));
            check_eq("out_src", 64'(out_src), 64'(m_head[W-1 -: IDW]));
        end

        dut_grant = -1;
        for (int i = 0; i < N; i++) if (in_ready[i]) dut_grant = i;
        if (dut_grant >= 0 && first_grant < 0) first_grant = cyc;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (|(in_valid & in_ready)) n_acc++;
        if (!rst && out_valid && out_ready) obs_q.push_back({out_src, out_data});

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_wr) begin
                m_q.push_back(e_wdata);
                m_ptr = win;
            end
            if (e_rd) begin
                if (m_q.size() == 0) begin
                    check_eq("model_underflow", 64'(1), 64'(0));
                end else begin
                    m_head = m_q.pop_front();
                end
            end
            m_count = m_count + (e_wr ? 1 : 0) - (e_rd ? 1 : 0);
            if (e_rd) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        rst       = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic track_reset();
        first_grant = -1;
        first_ov    = -1;
        n_acc       = 0;
        cyc         = 0;
        obs_q.delete();
    endtask

    initial begin
        int exp_skip [4];
        exp_skip = '{1, 3, 1, 3};
        rst       = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
        track_reset();
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with every requester asking
        repeat (2) step();
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("rst_empty", 64'(empty), 64'(1));

        // Round-robin fairness
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'(i * 16);
        track_reset();
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("rr_grant", 64'(dut_grant), 64'(c % N));
        end
        check_eq("rr_latency", 64'(first_ov - first_grant), 64'(2));
        check_eq("rr_obs_count", 64'(obs_q.size() >= 4), 64'(1));
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check_eq("rr_out_order", 64'(obs_q[i]), 64'({2'(i), 32'(i * 16)}));
        end
        drain(6);

        // Fill to full with a single producer and a stalled consumer
        track_reset();
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_data[2*DW +: DW] = $urandom;
            step();
        end
        check_eq("full_count", 64'(count), 64'(16));
        check_eq("full_flag", 64'(full), 64'(1));
        check_eq("full_accepted", 64'(n_acc), 64'(17));
        check_eq("full_no_ready", 64'(in_ready[2]), 64'(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check_eq("full_reopen", 64'(dut_grant), 64'(2));
        drain(24);

        // Backpressure hold
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        in_data[1*DW +: DW] = 32'hDEADBEEF;
        step();
        for (int c = 0; c < 2; c++) begin
            in_data[1*DW +: DW] = $urandom;
            step();
        end
        in_valid = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("hold_data", 64'(out_data), 64'(32'hDEADBEEF));
            check_eq("hold_src", 64'(out_src), 64'(1));
            check_eq("hold_rd_en", 64'(fifo_rd_en), 64'(0));
        end
        drain(8);

        // Skip idle requesters, starting from the reset pointer
        rst = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            check_eq("skip_grant", 64'(dut_grant), 64'(exp_skip[c]));
        end
        drain(6);

        // Reset with data in flight
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_data[0 +: DW] = $urandom;
            step();
        end
        check_eq("mid_count", 64'(count), 64'(7));
        check_eq("mid_ov", 64'(out_valid), 64'(1));
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = '0;
        check_eq("post_rst_count", 64'(count), 64'(0));
        check_eq("post_rst_ov", 64'(out_valid), 64'(0));
        check_eq("post_rst_empty", 64'(empty), 64'(1));
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 4'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain(20);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 4'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0) || (c % 100 > 60 && c % 100 < 70);
            if (c % 150 > 120) out_ready = 1'b0;
            step();
        end
        drain(24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
